// File: rtl/mvm_result_drain.sv
// Result drain for the matrix-vector multiplier: captures M words after each done, saturates them, and buffers them in a FIFO.
// Optional MVM_DRAIN_RELU_EN clamps negative results to zero before saturation.
module mvm_result_drain #(
  parameter int M         = 20,
  parameter int IN_WIDTH  = 16,
  parameter int RES_WIDTH = 8,
  parameter int DEPTH     = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 done,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [RES_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 can_start,
  output logic                 overflow,
  output logic                 dbg_state_o
);

  // Output stream: a word transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops and out_data/out_last never change until that transfer.

  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << (RES_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE = 1'b0, CAPTURE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [RES_WIDTH:0] mem_q [DEPTH];

  logic                       push, pop, push_last, free_ok;
  logic signed [IN_WIDTH-1:0] din_s;
  logic [RES_WIDTH-1:0]       sat_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    din_s = $signed(data_in);
`ifdef MVM_DRAIN_RELU_EN
    if (din_s[IN_WIDTH-1]) din_s = '0;
`endif
    if (din_s > SAT_MAX)      sat_word = SAT_MAX[RES_WIDTH-1:0];
    else if (din_s < SAT_MIN) sat_word = SAT_MIN[RES_WIDTH-1:0];
    else                      sat_word = din_s[RES_WIDTH-1:0];
  end

  // Room for a whole vector must exist when done arrives, so a push never meets a full FIFO.
  assign free_ok   = (count_q <= CNT_W'(DEPTH - M));
  assign push_last = (row_q == ROW_W'(M - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (done) begin
          if (free_ok) begin
            state_d = CAPTURE;
            row_d   = '0;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      CAPTURE: begin
        push = 1'b1;
        if (done) overflow_d = 1'b1;
        if (push_last) state_d = IDLE;
        else           row_d   = row_q + ROW_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, sat_word};
  end

  assign out_data    = out_valid ? mem_q[rd_ptr_q][RES_WIDTH-1:0] : '0;
  assign out_last    = out_valid ? mem_q[rd_ptr_q][RES_WIDTH] : 1'b0;
  assign can_start   = (state_q == IDLE) && free_ok;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mvm_result_drain.md
# mvm_result_drain

Downstream stage of the matrix-vector multiplier: watches the multiplier's `done`, captures the M result words it emits on the following M cycles, saturates each word to a narrower result width, and buffers them in a FIFO. Results leave on a valid/ready stream that marks the last word of each vector. The block also tells the controller when another `start` may be issued without losing results.

## Interface
- `M`, 20: rows per result vector (words captured per `done`).
- `IN_WIDTH`, 16: width of multiplier `data_out` (2× operand width), signed.
- `RES_WIDTH`, 8: output word width, signed; `RES_WIDTH` ≤ `IN_WIDTH`.
- `DEPTH`, 40: FIFO entries; `DEPTH` ≥ `M`.

- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `done` input 1: multiplier done pulse.
- `data_in` input `IN_WIDTH`: multiplier `data_out`, signed.
- `out_data` output `RES_WIDTH`: head-of-FIFO word, signed.
- `out_valid` output 1: `out_data` valid.
- `out_last` output 1: head word is row M-1 of its vector.
- `out_ready` input 1: consumer accepts the head word.
- `can_start` output 1: a `start` issued now is safe; high when idle and free entries ≥ M.
- `overflow` output 1: sticky; a result vector was dropped.

## Operation
- States: IDLE, CAPTURE.
- IDLE: `done`=1 and free ≥ M → CAPTURE, row counter := 0. `done`=1 and free < M → stay IDLE, set `overflow`, drop that vector (no words written).
- CAPTURE: in cycle k+1+j (k = cycle `done` was high), `data_in` holds row j; at the end of that cycle, write sat(`data_in`) with a last-tag = (j == M-1). After the write of j = M-1 → IDLE.
- `done` seen while in CAPTURE: ignored for capture, sets `overflow`.
- Saturation: clamp signed `data_in` to [-2^(RES_WIDTH-1), 2^(RES_WIDTH-1)-1]; in-range values pass unchanged (sign-truncate).
- FIFO: show-ahead; `out_data`/`out_last` reflect the head entry whenever `out_valid`=1. Pop on `out_valid && out_ready`. Push and pop in the same cycle are allowed, and the occupancy is unchanged.
- Free-entry count = `DEPTH` - occupancy. The free-slot check at `done` guarantees a push never meets a full FIFO. Read/write pointers wrap modulo `DEPTH` (no power-of-2 requirement).
- `can_start` = (state == IDLE) && (free ≥ M); combinational from registered state/count.
- `out_data`/`out_last` are don't-care while `out_valid`=0 but driven to 0 from a reset FIFO.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, FIFO empty, pointers 0, `overflow`=0. Next cycle: `out_valid`=0, `out_last`=0, `out_data`=0, `can_start`=1.
- Reset mid-CAPTURE or with data buffered: abort capture, flush FIFO; partial vector is lost.
- Latency: row 0 is on `data_in` in cycle k+1, and `out_valid`=1 in cycle k+2 if the FIFO was empty.
- Back-to-back: with `out_ready`=1 and the FIFO empty, one word per cycle, rows 0..M-1 in cycles k+2..k+M+1, `out_last` in cycle k+M+1.
- `can_start` drops in cycle k+1 (CAPTURE) and returns in cycle k+M+1 at the earliest.
- `out_valid` holds, and `out_data` stays stable, until it is accepted.

## Configuration
- `MVM_DRAIN_RELU_EN` defined: negative `data_in` is replaced by 0 before saturation, so output range is [0, 2^(RES_WIDTH-1)-1].
- Undefined: signed saturation only; negative results pass through.

## Test plan
- Reset, then `done` pulse with rows 0..19 = 5, -3, 127, 128, -128, -129, 32767, -32768, then 12×1, `out_ready`=1 → out 5, -3, 127, 127, -128, -128, 127, -128, 1…; `out_last` only on the 20th; `out_valid` first in cycle k+2.
- Two vectors with `out_ready`=0 (40 words buffered) → `can_start`=0; a third `done` sets `overflow`=1 and writes nothing. Then `out_ready`=1 → exactly 40 words, `out_last` on words 20 and 40.
- `out_ready` toggled 1,0,1,0 during a drain → no word lost or duplicated; `out_data` stable while stalled.
- `reset`=0 in cycle k+10 of a capture → `out_valid`=0 next cycle, `can_start`=1, `overflow`=0; a following vector is captured cleanly.
- Second `done` asserted during CAPTURE → `overflow`=1 and the current vector completes intact.
- With `MVM_DRAIN_RELU_EN`: rows -1, -300, 50, 300 → 0, 0, 50, 127.
